vx_mem_sched: RTL and testbench

- Shares one Vortex-side memory request/response port (the AXI adapter's upstream side) among NUM_REQS requesters.
- Arbitrates round-robin and widens the tag with the requester index.
- Tracks outstanding reads against a credit limit and routes read responses back to the requester that issued them.
- Offers a flush sequence that stops issue and reports when all reads have drained; used before cache/memory reconfiguration.

---
 rtl/vx_mem_sched_pkg.sv | 26 ++
 rtl/vx_mem_sched_credit.sv | 31 +++
 rtl/vx_mem_sched.sv | 201 ++++++++++++++++++++
 tb/tb_vx_mem_sched.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_mem_sched_pkg.sv
// Shared types and helpers for the memory request scheduler.
package vx_mem_sched_pkg;

    localparam int DEF_NUM_REQS    = 4;
    localparam int DEF_DATA_WIDTH  = 512;
    localparam int DEF_ADDR_WIDTH  = 26;
    localparam int DEF_TAG_WIDTH   = 8;
    localparam int DEF_MAX_PENDING = 16;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } sched_state_e;

    // Index fields never collapse to zero width, even for a single requester.
    function automatic int log2up(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Downstream tag is {requester tag, requester index}.
    function automatic int mem_tag_width(input int tag_w, input int num_reqs);
        return tag_w + log2up(num_reqs);
    endfunction

endpackage

// File: rtl/vx_mem_sched_credit.sv
// Outstanding-read counter for the scheduler; flags when another read may issue.
module vx_mem_sched_credit
    import vx_mem_sched_pkg::*;
#(
    parameter int MAX_PENDING = DEF_MAX_PENDING,
    parameter int CNT_W       = log2up(MAX_PENDING + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             credit_ok
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !dec) begin
            count <= count + CNT_W'(1);
        end else if (dec && !inc && count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign credit_ok = (count < CNT_W'(MAX_PENDING));

    // A response with nothing outstanding means the downstream side is broken.
    underflow_chk: assert property (@(posedge clk) disable iff (reset) dec |-> (count != '0));

endmodule

// File: rtl/vx_mem_sched.sv
// Round-robin sharing of one memory port among NUM_REQS requesters, with read
// credit tracking and a flush/drain sequence. Optional perf counters: VX_MEM_SCHED_PERF_EN.
module vx_mem_sched
    import vx_mem_sched_pkg::*;
#(
    parameter int NUM_REQS     = DEF_NUM_REQS,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int TAG_WIDTH    = DEF_TAG_WIDTH,
    parameter int MAX_PENDING  = DEF_MAX_PENDING,
    parameter int REQ_SEL_BITS = log2up(NUM_REQS),
    parameter int MTAG_W       = mem_tag_width(TAG_WIDTH, NUM_REQS),
    parameter int CNT_W        = log2up(MAX_PENDING + 1)
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_REQS-1:0]                     req_valid,
    input  logic [NUM_REQS-1:0]                     req_rw,
    input  logic [NUM_REQS-1:0][DATA_WIDTH/8-1:0]   req_byteen,
    input  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]     req_addr,
    input  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]     req_data,
    input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]      req_tag,
    output logic [NUM_REQS-1:0]                     req_ready,
    output logic [NUM_REQS-1:0]                     rsp_valid,
    output logic [NUM_REQS-1:0][DATA_WIDTH-1:0]     rsp_data,
    output logic [NUM_REQS-1:0][TAG_WIDTH-1:0]      rsp_tag,
    input  logic [NUM_REQS-1:0]                     rsp_ready,
    output logic                                    mem_req_valid,
    output logic                                    mem_req_rw,
    output logic [DATA_WIDTH/8-1:0]                 mem_req_byteen,
    output logic [ADDR_WIDTH-1:0]                   mem_req_addr,
    output logic [DATA_WIDTH-1:0]                   mem_req_data,
    output logic [MTAG_W-1:0]                       mem_req_tag,
    input  logic                                    mem_req_ready,
    input  logic                                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]                   mem_rsp_data,
    input  logic [MTAG_W-1:0]                       mem_rsp_tag,
    output logic                                    mem_rsp_ready,
    input  logic                                    flush_req,
    output logic                                    flush_done,
    output logic [CNT_W-1:0]                        pending_count
`ifdef VX_MEM_SCHED_PERF_EN
    ,
    output logic [63:0]                             perf_reads,
    output logic [63:0]                             perf_writes,
    output logic [63:0]                             perf_stall_cycles
`endif
);

    localparam int SEL = REQ_SEL_BITS;
    localparam int BEW = DATA_WIDTH / 8;

    typedef struct packed {
        logic                  rw;
        logic [BEW-1:0]        byteen;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [MTAG_W-1:0]     tag;
    } mreq_t;

    sched_state_e        state_q, state_d;
    logic [SEL-1:0]      rr_ptr, win_idx, cand;
    logic                win_found, fire, credit_ok, run_ok, buf_ready;
    logic [NUM_REQS-1:0] elig;
    mreq_t               win_req;
    mreq_t               buf_q [2];
    logic [1:0]          buf_cnt;
    logic                wr_ptr, rd_ptr, pop, rsp_fire;

    // Reset gating keeps req_ready low while reset is held.
    assign run_ok = (state_q == ST_RUN) && !reset;
    assign elig   = req_valid & (req_rw | {NUM_REQS{credit_ok}}) & {NUM_REQS{run_ok}};

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            cand = SEL'((int'(rr_ptr) + k) % NUM_REQS);
            if (!win_found && |(elig & (NUM_REQS'(1) << cand))) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign buf_ready = (buf_cnt != 2'd2);
    assign fire      = win_found && buf_ready;

    always_comb begin
        win_req.rw     = req_rw[win_idx];
        win_req.byteen = req_byteen[win_idx];
        win_req.addr   = req_addr[win_idx];
        win_req.data   = req_data[win_idx];
        win_req.tag    = {req_tag[win_idx], win_idx};
    end

    generate
        for (genvar i = 0; i < NUM_REQS; i++) begin : g_ready
            assign req_ready[i] = fire && (win_idx == SEL'(i));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (fire) begin
            rr_ptr <= (win_idx == SEL'(NUM_REQS - 1)) ? '0 : win_idx + SEL'(1);
        end
    end

    // Two-entry elastic stage: registered output, one push and one pop per cycle.
    assign pop = mem_req_valid && mem_req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_cnt   <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            buf_q[0]  <= '0;
            buf_q[1]  <= '0;
        end else begin
            if (fire) begin
                buf_q[wr_ptr] <= win_req;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            buf_cnt <= buf_cnt + 2'(fire) - 2'(pop);
        end
    end

    assign mem_req_valid  = (buf_cnt != 2'd0);
    assign mem_req_rw     = buf_q[rd_ptr].rw;
    assign mem_req_byteen = buf_q[rd_ptr].byteen;
    assign mem_req_addr   = buf_q[rd_ptr].addr;
    assign mem_req_data   = buf_q[rd_ptr].data;
    assign mem_req_tag    = buf_q[rd_ptr].tag;

    // Responses route combinationally by the index carried in the tag LSBs.
    logic [SEL-1:0]      rsp_idx;
    logic [NUM_REQS-1:0] rsp_sel;

    assign rsp_idx = (NUM_REQS == 1) ? '0 : mem_rsp_tag[SEL-1:0];

    generate
        for (genvar i = 0; i < NUM_REQS; i++) begin : g_rsp
            assign rsp_sel[i]   = (rsp_idx == SEL'(i));
            assign rsp_valid[i] = mem_rsp_valid && rsp_sel[i];
            assign rsp_data[i]  = mem_rsp_data;
            assign rsp_tag[i]   = mem_rsp_tag[MTAG_W-1:SEL];
        end
    endgenerate

    assign mem_rsp_ready = |(rsp_ready & rsp_sel);
    assign rsp_fire      = mem_rsp_valid && mem_rsp_ready;

    vx_mem_sched_credit #(
        .MAX_PENDING (MAX_PENDING),
        .CNT_W       (CNT_W)
    ) credit (
        .clk       (clk),
        .reset     (reset),
        .inc       (fire && !win_req.rw),
        .dec       (rsp_fire),
        .count     (pending_count),
        .credit_ok (credit_ok)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (flush_req) state_d = ST_DRAIN;
            ST_DRAIN: if (buf_cnt == 2'd0 && pending_count == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    assign flush_done = (state_q == ST_DONE);

`ifdef VX_MEM_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_reads        <= '0;
            perf_writes       <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (fire && !win_req.rw) perf_reads  <= perf_reads + 64'd1;
            if (fire && win_req.rw)  perf_writes <= perf_writes + 64'd1;
            if (state_q == ST_RUN && |req_valid && !fire)
                perf_stall_cycles <= perf_stall_cycles + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vx_mem_sched.sv
// Directed bench for vx_mem_sched: arbitration, credits, response routing, flush, reset.
module tb_vx_mem_sched;

    localparam int NR = 4, DW = 32, AW = 8, TW = 8, MP = 6, SEL = 2, MTW = TW + SEL, CW = 3;

    logic                     clk = 1'b0, reset = 1'b1;
    logic [NR-1:0]            req_valid = '0, req_rw = '0, req_ready;
    logic [NR-1:0][DW/8-1:0]  req_byteen = '0;
    logic [NR-1:0][AW-1:0]    req_addr = '0;
    logic [NR-1:0][DW-1:0]    req_data = '0;
    logic [NR-1:0][TW-1:0]    req_tag = '0;
    logic [NR-1:0]            rsp_valid, rsp_ready = '0;
    logic [NR-1:0][DW-1:0]    rsp_data;
    logic [NR-1:0][TW-1:0]    rsp_tag;
    logic                     mem_req_valid, mem_req_rw, mem_req_ready = 1'b0;
    logic [DW/8-1:0]          mem_req_byteen;
    logic [AW-1:0]            mem_req_addr;
    logic [DW-1:0]            mem_req_data;
    logic [MTW-1:0]           mem_req_tag;
    logic                     mem_rsp_valid = 1'b0, mem_rsp_ready;
    logic [DW-1:0]            mem_rsp_data = '0;
    logic [MTW-1:0]           mem_rsp_tag = '0;
    logic                     flush_req = 1'b0, flush_done;
    logic [CW-1:0]            pending_count;
`ifdef VX_MEM_SCHED_PERF_EN
    logic [63:0]              perf_reads, perf_writes, perf_stall_cycles;
`endif

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    vx_mem_sched #(
        .NUM_REQS(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .MAX_PENDING(MP)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_rw(req_rw), .req_byteen(req_byteen), .req_addr(req_addr),
        .req_data(req_data), .req_tag(req_tag), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_ready(rsp_ready),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_byteen(mem_req_byteen),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
        .mem_rsp_ready(mem_rsp_ready),
        .flush_req(flush_req), .flush_done(flush_done), .pending_count(pending_count)
`ifdef VX_MEM_SCHED_PERF_EN
        , .perf_reads(perf_reads), .perf_writes(perf_writes), .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            req_tag[i]    = TW'(8'h10 + i);
            req_addr[i]   = AW'(8'h30 + i);
            req_data[i]   = DW'(32'hA000 + i);
            req_byteen[i] = '1;
        end

        // Reset state
        tick(); tick();
        reset = 1'b0;
        #2;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_flush_done", 64'(flush_done), 64'd0);
        chk("rst_pending", 64'(pending_count), 64'd0);

        // Four reads round-robin, one mem_req per cycle after one cycle of latency
        req_valid = 4'b1111; req_rw = '0; mem_req_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("rr_ready", 64'(req_ready), 64'(4'b0001 << k));
            tick();
            if (k == 3) req_valid = '0;
            #2;
            chk("rr_mvalid", 64'(mem_req_valid), 64'd1);
            chk("rr_mtag", 64'(mem_req_tag), 64'({8'(8'h10 + k), 2'(k)}));
            chk("rr_maddr", 64'(mem_req_addr), 64'(8'h30 + k));
            chk("rr_pending", 64'(pending_count), 64'(k + 1));
        end
        tick(); #2;
        chk("rr_idle", 64'(mem_req_valid), 64'd0);

        // Response routing with back-pressure from requester 3
        mem_rsp_valid = 1'b1; mem_rsp_tag = {8'h5A, 2'd3}; mem_rsp_data = 32'hDEADBEEF;
        rsp_ready = 4'b0111;
        #1;
        chk("rsp_valid3", 64'(rsp_valid), 64'(4'b1000));
        chk("rsp_tag3", 64'(rsp_tag[3]), 64'h5A);
        for (int k = 0; k < 3; k++) begin
            tick(); #2;
            chk("rsp_hold_ready", 64'(mem_rsp_ready), 64'd0);
            chk("rsp_hold_data", 64'(rsp_data[3]), 64'hDEADBEEF);
            chk("rsp_hold_pend", 64'(pending_count), 64'd4);
        end
        rsp_ready = 4'b1111;
        #1;
        chk("rsp_accept", 64'(mem_rsp_ready), 64'd1);
        tick();
        mem_rsp_tag = {8'h11, 2'd1};
        #2;
        chk("rsp_pend3", 64'(pending_count), 64'd3);
        chk("rsp_valid1", 64'(rsp_valid), 64'(4'b0010));
        chk("rsp_tag1", 64'(rsp_tag[1]), 64'h11);
        tick(); mem_rsp_tag = {8'h12, 2'd0};
        tick(); mem_rsp_tag = {8'h13, 2'd2};
        tick(); mem_rsp_valid = 1'b0;
        #2;
        chk("rsp_pend0", 64'(pending_count), 64'd0);

        // Credit limit (MAX_PENDING=6): reads stall, writes still pass
        req_tag[0] = 8'h20; req_valid = 4'b0001; req_rw = '0;
        for (int k = 0; k < 6; k++) begin
            #2;
            chk("cred_grant", 64'(req_ready), 64'(4'b0001));
            tick();
        end
        #2;
        chk("cred_full", 64'(pending_count), 64'd6);
        chk("cred_stall", 64'(req_ready), 64'd0);
        req_valid = 4'b0011; req_rw = 4'b0010;
        #2;
        chk("cred_write_ok", 64'(req_ready), 64'(4'b0010));
        tick();
        req_valid = 4'b0001;
        #2;
        chk("cred_write_nopend", 64'(pending_count), 64'd6);
        chk("cred_write_out", 64'(mem_req_rw), 64'd1);
        chk("cred_still_stall", 64'(req_ready), 64'd0);
        mem_rsp_valid = 1'b1; mem_rsp_tag = {8'h20, 2'd0};
        #2;
        chk("cred_rsp_ready", 64'(mem_rsp_ready), 64'd1);
        tick();
        mem_rsp_valid = 1'b0;
        #2;
        chk("cred_freed", 64'(pending_count), 64'd5);
        chk("cred_resume", 64'(req_ready), 64'(4'b0001));
        tick(); #2;
        chk("cred_refull", 64'(pending_count), 64'd6);

        // Grant and response in the same cycle leave the count unchanged
        mem_rsp_valid = 1'b1;
        tick(); #2;
        chk("same_pend5", 64'(pending_count), 64'd5);
        chk("same_grant", 64'(req_ready), 64'(4'b0001));
        chk("same_rsp", 64'(mem_rsp_ready), 64'd1);
        tick();
        mem_rsp_valid = 1'b0; req_valid = '0;
        #2;
        chk("same_hold5", 64'(pending_count), 64'd5);
        mem_rsp_valid = 1'b1;
        tick(); tick();
        mem_rsp_valid = 1'b0;
        #2;
        chk("pre_flush_pend", 64'(pending_count), 64'd3);

        // Flush: one write stuck in the buffer plus three reads outstanding
        mem_req_ready = 1'b0; req_valid = 4'b0100; req_rw = 4'b0100;
        #2;
        chk("fl_prewrite", 64'(req_ready), 64'(4'b0100));
        tick();
        req_valid = '0; flush_req = 1'b1;
        #2;
        chk("fl_buf_busy", 64'(mem_req_valid), 64'd1);
        tick();
        flush_req = 1'b0; req_valid = 4'b1111; req_rw = '0;
        #2;
        chk("fl_nogrant", 64'(req_ready), 64'd0);
        chk("fl_nodone", 64'(flush_done), 64'd0);
        tick();
        flush_req = 1'b1;
        #2;
        chk("fl_nogrant2", 64'(req_ready), 64'd0);
        tick();
        flush_req = 1'b0; mem_req_ready = 1'b1;
        #2;
        chk("fl_buf_hold", 64'(mem_req_valid), 64'd1);
        tick(); #2;
        chk("fl_buf_empty", 64'(mem_req_valid), 64'd0);
        chk("fl_wait_rsp", 64'(flush_done), 64'd0);
        mem_rsp_valid = 1'b1; mem_rsp_tag = {8'h20, 2'd0};
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("fl_drain_done", 64'(flush_done), 64'd0);
            chk("fl_drain_grant", 64'(req_ready), 64'd0);
            tick();
        end
        mem_rsp_valid = 1'b0;
        #2;
        chk("fl_pend0", 64'(pending_count), 64'd0);
        chk("fl_not_yet", 64'(flush_done), 64'd0);
        tick();
        flush_req = 1'b1;
        #2;
        chk("fl_done", 64'(flush_done), 64'd1);
        chk("fl_done_nogrant", 64'(req_ready), 64'd0);
        tick();
        flush_req = 1'b0;
        #2;
        chk("fl_pulse", 64'(flush_done), 64'd0);
        chk("fl_run_grant", 64'(req_ready), 64'(4'b1000));
        tick(); #2;
        chk("fl_run_next", 64'(req_ready), 64'(4'b0001));
        tick();

        // Reset in the middle of a burst
        reset = 1'b1;
        #2;
        chk("mr_ready_in_rst", 64'(req_ready), 64'd0);
        tick(); #2;
        chk("mr_mvalid", 64'(mem_req_valid), 64'd0);
        chk("mr_mtag", 64'(mem_req_tag), 64'd0);
        chk("mr_pending", 64'(pending_count), 64'd0);
        chk("mr_flush_done", 64'(flush_done), 64'd0);
        chk("mr_rsp_valid", 64'(rsp_valid), 64'd0);
        reset = 1'b0;
        #2;
        chk("mr_ptr0", 64'(req_ready), 64'(4'b0001));
        tick(); #2;
        chk("mr_first_tag", 64'(mem_req_tag), 64'({8'h20, 2'd0}));
        chk("mr_first_pend", 64'(pending_count), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
